// File: rtl/turbine_pkg.sv
// Shared constants and types for the multi-channel turbine pulse generator.
package turbine_pkg;

    localparam int unsigned TURBINE_NUM_DEF = 10;
    localparam int unsigned CNT_W_DEF       = 32;
    localparam int unsigned CH_W            = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/turbine_pulse_gen_if.sv
// Configuration write port shared by all pulse generator channels.
interface turbine_pulse_gen_if #(
    parameter int unsigned CNT_W = turbine_pkg::CNT_W_DEF
) ();
    import turbine_pkg::*;

    // Handshake: cfg_wr_en_i is a one-cycle valid with an implicit, always-asserted
    // ready; every edge that sees it high commits the write, so no back-pressure exists.
    logic              cfg_wr_en_i;
    logic [CH_W-1:0]   cfg_ch_i;
    logic              cfg_en_i;
    logic [CNT_W-1:0]  cfg_period_i;
    logic [CNT_W-1:0]  cfg_high_i;

    modport master (
        output cfg_wr_en_i, cfg_ch_i, cfg_en_i, cfg_period_i, cfg_high_i
    );

    modport slave (
        input cfg_wr_en_i, cfg_ch_i, cfg_en_i, cfg_period_i, cfg_high_i
    );

endinterface

// File: rtl/turbine_pulse_ch.sv
// One pulse channel: shadow config, active config latched at period boundaries,
// IDLE/RUN state machine, cycle counter and registered pulse output.
module turbine_pulse_ch
    import turbine_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en_i,
    input  logic             cfg_en_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    output logic             pulse_o,
    output logic             wrap_o,
    output ch_state_e        state_o
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(2);

    ch_state_e        state_q, state_d;
    logic             sh_en_q, sh_en_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             wrap_q, wrap_d;

    logic cfg_ok_q;
    logic cfg_ok_byp;
    logic last_cycle;

    // Starting from IDLE uses the registered shadow (one-cycle start latency);
    // a wrap uses the bypassed shadow so a coincident write lands in the next period.
    assign cfg_ok_q   = sh_en_q && (sh_period_q >= MIN_PERIOD);
    assign cfg_ok_byp = sh_en_d && (sh_period_d >= MIN_PERIOD);
    assign last_cycle = (cnt_q == act_period_q - ONE);

    always_comb begin
        sh_en_d      = wr_en_i ? cfg_en_i     : sh_en_q;
        sh_period_d  = wr_en_i ? cfg_period_i : sh_period_q;
        sh_high_d    = wr_en_i ? cfg_high_i   : sh_high_q;
        state_d      = state_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_ok_q) begin
                    state_d      = RUN;
                    act_period_d = sh_period_q;
                    act_high_d   = sh_high_q;
                end
            end
            RUN: begin
                if (last_cycle) begin
                    cnt_d = '0;
                    if (cfg_ok_byp) begin
                        act_period_d = sh_period_d;
                        act_high_d   = sh_high_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        pulse_d = (state_q == RUN) && (cnt_q < act_high_q);
        // Registered so it is high exactly while cnt sits on act_period-1.
        wrap_d  = (state_d == RUN) && (cnt_d == act_period_d - ONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            sh_en_q      <= 1'b0;
            sh_period_q  <= '0;
            sh_high_q    <= '0;
            act_period_q <= '0;
            act_high_q   <= '0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_en_q      <= sh_en_d;
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
            wrap_q       <= wrap_d;
        end
    end

    assign pulse_o = pulse_q;
    assign wrap_o  = wrap_q;
    assign state_o = state_q;

endmodule

// File: rtl/turbine_pulse_gen.sv
// Multi-channel turbine pulse generator: decodes the shared write port into
// per-channel strobes and instantiates one independent channel per output pin.
module turbine_pulse_gen
    import turbine_pkg::*;
#(
    parameter int unsigned TURBINE_NUM = TURBINE_NUM_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_n_i,
    turbine_pulse_gen_if.slave     cfg_if,
    output logic [TURBINE_NUM-1:0] TURBINE_OUT,
    output logic [TURBINE_NUM-1:0] busy_o,
    output logic [TURBINE_NUM-1:0] wrap_o
);

    for (genvar i = 0; i < TURBINE_NUM; i++) begin : g_ch
        ch_state_e st;
        logic      wr_en;

        // Indices at or beyond TURBINE_NUM match no channel and are dropped.
        assign wr_en = cfg_if.cfg_wr_en_i && (cfg_if.cfg_ch_i == CH_W'(i));

        turbine_pulse_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk_i        (sys_clk_i),
            .rst_n_i      (rst_n_i),
            .wr_en_i      (wr_en),
            .cfg_en_i     (cfg_if.cfg_en_i),
            .cfg_period_i (cfg_if.cfg_period_i),
            .cfg_high_i   (cfg_if.cfg_high_i),
            .pulse_o      (TURBINE_OUT[i]),
            .wrap_o       (wrap_o[i]),
            .state_o      (st)
        );

        assign busy_o[i] = (st == RUN);
    end

endmodule

// File: tb/tb_turbine_pulse_gen.sv
// Directed bench for turbine_pulse_gen: per-period high/length records are
// predicted by the stimulus and checked by an independent negedge monitor.
module tb_turbine_pulse_gen;
    import turbine_pkg::*;

    localparam int N  = 10;
    localparam int CW = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] t_out;
    logic [N-1:0] busy;
    logic [N-1:0] wrap;

    turbine_pulse_gen_if #(.CNT_W(CW)) cfg_if ();

    turbine_pulse_gen #(
        .TURBINE_NUM (N),
        .CNT_W       (CW)
    ) dut (
        .sys_clk_i   (clk),
        .rst_n_i     (rst_n),
        .cfg_if      (cfg_if),
        .TURBINE_OUT (t_out),
        .busy_o      (busy),
        .wrap_o      (wrap)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [35:0]  exp_q[$];
    int           compared = 0;
    int           mismatched = 0;
    logic [N-1:0] quiet_mask = '1;
    int           hi_cnt[N];
    int           len_cnt[N];
    logic [N-1:0] busy_prev = '0;
    logic [N-1:0] wrap_pend = '0;

    function automatic logic [35:0] rec(int ch, int hi, int len);
        return {4'(ch), 16'(hi), 16'(len)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_periods(int ch, int period, int high, int count);
        int hi;
        hi = (high > period) ? period : high;
        for (int k = 0; k < count; k++) exp_q.push_back(rec(ch, hi, period));
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(int ch, bit en, int period, int high);
        cfg_if.cfg_ch_i     = 4'(ch);
        cfg_if.cfg_en_i     = en;
        cfg_if.cfg_period_i = 32'(period);
        cfg_if.cfg_high_i   = 32'(high);
        cfg_if.cfg_wr_en_i  = 1'b1;
        @(negedge clk);
        cfg_if.cfg_wr_en_i  = 1'b0;
    endtask

    task automatic wait_wrap(int ch);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (wrap[ch]) return;
        end
        compared++;
        mismatched++;
        $display("FAIL wait_wrap ch%0d: no wrap_o within 3000 cycles, required one", ch);
    endtask

    task automatic wait_idle(int ch);
        for (int k = 0; k < 3000; k++) begin
            if (!busy[ch]) return;
            @(negedge clk);
        end
        compared++;
        mismatched++;
        $display("FAIL wait_idle ch%0d: busy_o still 1 after 3000 cycles, required 0", ch);
    endtask

    // Start, let `waits` wraps pass, then disable in the middle of the next period.
    task automatic run_and_stop(int ch, int period, int high, int waits);
        push_periods(ch, period, high, waits + 1);
        wr(ch, 1'b1, period, high);
        repeat (waits) wait_wrap(ch);
        cycles(1);
        wr(ch, 1'b0, period, high);
        wait_idle(ch);
        cycles(3);
        check($sformatf("idle_after_stop_ch%0d", ch), 64'(busy[ch] | t_out[ch]), 64'd0);
    endtask

    // ---------------- monitor ----------------
    // A period window spans the output samples that reflect cnt 0..period-1,
    // i.e. it closes one sample after the wrap_o sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = '0;
            wrap_pend = '0;
        end else begin
            check("quiet_channels", 64'((t_out | busy | wrap) & quiet_mask), 64'd0);
            for (int ch = 0; ch < N; ch++) begin
                if (!busy_prev[ch]) begin
                    hi_cnt[ch]  = 0;
                    len_cnt[ch] = 0;
                end else begin
                    hi_cnt[ch]  = hi_cnt[ch] + int'(t_out[ch]);
                    len_cnt[ch] = len_cnt[ch] + 1;
                end
                if (wrap_pend[ch]) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL period_record: got ch%0d high=%0d len=%0d, required no record",
                                 ch, hi_cnt[ch], len_cnt[ch]);
                    end else begin
                        logic [35:0] e;
                        e = exp_q.pop_front();
                        check($sformatf("period_record_ch%0d", ch),
                              64'(rec(ch, hi_cnt[ch], len_cnt[ch])), 64'(e));
                    end
                    hi_cnt[ch]  = 0;
                    len_cnt[ch] = 0;
                end
                wrap_pend[ch] = wrap[ch];
                busy_prev[ch] = busy[ch];
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cfg_if.cfg_wr_en_i  = 1'b0;
        cfg_if.cfg_ch_i     = '0;
        cfg_if.cfg_en_i     = 1'b0;
        cfg_if.cfg_period_i = '0;
        cfg_if.cfg_high_i   = '0;
        rst_n = 1'b0;
        cycles(3);
        check("reset_out",  64'(t_out), 64'd0);
        check("reset_busy", 64'(busy),  64'd0);
        check("reset_wrap", 64'(wrap),  64'd0);
        rst_n = 1'b1;
        cycles(2);

        // ch0 1000/300: start latency, two full periods, stop at wrap
        quiet_mask = ~10'b1;
        push_periods(0, 1000, 300, 2);
        wr(0, 1'b1, 1000, 300);
        check("start_e0_busy", 64'(busy[0]), 64'd0);
        cycles(1);
        check("start_e1_busy", 64'(busy[0]), 64'd1);
        check("start_e1_out",  64'(t_out[0]), 64'd0);
        cycles(1);
        check("start_e2_out",  64'(t_out[0]), 64'd1);
        wait_wrap(0);
        cycles(5);
        wr(0, 1'b0, 1000, 300);
        wait_wrap(0);
        check("stop_busy_in_wrap", 64'(busy[0]), 64'd1);
        cycles(1);
        check("stop_busy_after_wrap", 64'(busy[0]), 64'd0);
        cycles(3);
        check("stop_out_low", 64'(t_out[0]), 64'd0);
        quiet_mask = '1;

        // ch9 100/50 reconfigured mid-period to 40/10
        quiet_mask = ~(10'b1 << 9);
        push_periods(9, 100, 50, 1);
        push_periods(9, 40, 10, 2);
        wr(9, 1'b1, 100, 50);
        cycles(30);
        wr(9, 1'b1, 40, 10);
        wait_wrap(9);
        wait_wrap(9);
        cycles(3);
        wr(9, 1'b0, 40, 10);
        wait_idle(9);
        cycles(3);
        quiet_mask = '1;

        // ch3 edge values
        quiet_mask = ~(10'b1 << 3);
        run_and_stop(3, 2, 1, 3);
        run_and_stop(3, 2, 0, 2);
        run_and_stop(3, 5, 7, 2);
        quiet_mask = '1;

        // invalid writes
        wr(12, 1'b1, 10, 5);
        cycles(10);
        check("ch12_ignored", 64'(busy), 64'd0);
        wr(5, 1'b1, 1, 1);
        cycles(10);
        check("period1_stays_idle", 64'(busy[5]), 64'd0);

        // write coinciding with wrap on ch1
        quiet_mask = ~10'b10;
        push_periods(1, 10, 4, 1);
        push_periods(1, 6, 2, 2);
        wr(1, 1'b1, 10, 4);
        wait_wrap(1);
        wr(1, 1'b1, 6, 2);
        check("coincident_still_busy", 64'(busy[1]), 64'd1);
        wait_wrap(1);
        cycles(1);
        wr(1, 1'b0, 6, 2);
        wait_idle(1);
        cycles(3);
        quiet_mask = '1;

        // reset during the high phase of every channel
        quiet_mask = '0;
        for (int i = 0; i < N; i++) wr(i, 1'b1, 200, 100);
        cycles(5);
        check("all_high_before_reset", 64'(t_out), 64'h3ff);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_out",  64'(t_out), 64'd0);
        check("reset_mid_busy", 64'(busy),  64'd0);
        cycles(2);
        rst_n = 1'b1;
        quiet_mask = '1;
        cycles(20);
        check("post_reset_idle", 64'(busy | t_out), 64'd0);
        cycles(5);

        check("records_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/turbine_pulse_gen.md
# turbine_pulse_gen

Multi-channel turbine pulse generator, the transmit-side counterpart of the turbine period/high-time acquisition path. Each channel emits a periodic square wave, with period and high time in sys_clk_i cycles taken from a configuration write port. Outputs drive the TURBINE_START pins of the acquisition channels for board self-test, or external turbine simulators. Configuration changes take effect only at period boundaries, so output pulses are never truncated or glitched.

## Interface
- TURBINE_NUM, 10, number of channels (1..16)
- CNT_W, 32, width of period/high-time values and counters
- sys_clk_i  in  1  system clock; all logic on rising edge
- rst_n_i  in  1  reset; synchronous and active-low
- cfg_wr_en_i  in  1  one-cycle configuration write strobe
- cfg_ch_i  in  4  target channel index; writes with cfg_ch_i >= TURBINE_NUM are ignored
- cfg_en_i  in  1  channel run enable written with the strobe
- cfg_period_i  in  CNT_W  period in cycles
- cfg_high_i  in  CNT_W  high time in cycles
- TURBINE_OUT  out  TURBINE_NUM  registered pulse outputs
- busy_o  out  TURBINE_NUM  channel is in RUN
- wrap_o  out  TURBINE_NUM  one-cycle pulse on the last cycle of each completed period

## Operation
- Per channel shadow registers {en, period, high}:
  - Updated on the edge that samples cfg_wr_en_i with a matching cfg_ch_i.
  - Multiple writes before a boundary: the last write wins.
- Active registers {period, high} are loaded from shadow only on IDLE->RUN and at each period wrap.
- Valid configuration means shadow en=1 and shadow period >= 2.
- Per-channel FSM:
  - IDLE: cnt=0, output low. Moves to RUN when the configuration is valid; active registers load and cnt=0 on that edge.
  - RUN: cnt increments each cycle.
    - When cnt==act_period-1: cnt<=0, wrap_o asserts for that cycle, and active registers reload from shadow.
    - If the configuration is no longer valid at the wrap, the channel returns to IDLE instead.
    - Disabling a channel never cuts a period short.
- Output register: TURBINE_OUT[i] <= (state==RUN) && (cnt < act_high).
  - act_high=0 gives a constant low output.
  - act_high >= act_period gives a constant high output.
- Compare is unsigned over the full CNT_W bits; cnt never exceeds act_period-1, so no wrap-around of cnt is possible.
- Channels are fully independent. The same write port serves all channels; only one channel can be written per cycle.

## Timing
- Reset values:
  - TURBINE_OUT=0, busy_o=0, wrap_o=0
  - all channels IDLE, cnt=0
  - shadow and active registers all 0
- Reset mid-operation forces the output low on the next edge with no completion of the current period.
- Start latency for an IDLE channel:
  - Write sampled at edge E0.
  - IDLE->RUN at edge E1; busy_o high after E1.
  - TURBINE_OUT high after edge E2 (when high > 0).
- Steady state: TURBINE_OUT is high for exactly act_high cycles out of every act_period cycles. Rising edges are act_period cycles apart.
- A new period/high written mid-period takes effect on the first rising output edge after the next wrap_o.
- A write on the same edge as a wrap reloads the active registers with the new shadow value: write and load coincide, and the shadow bypasses to the active registers.
- Stop: after cfg_en_i=0 is written, the current period finishes. busy_o drops on the edge after the wrap_o cycle, and TURBINE_OUT stays low from then on.

## Structure
- Package turbine_pkg holds:
  - TURBINE_NUM default, CNT_W default, channel index width
  - channel state enum {IDLE, RUN}
- Sub-module turbine_pulse_ch contains one channel: shadow registers, active registers, FSM, counter and output register.
  - The top decodes cfg_ch_i into per-channel write strobes and generates TURBINE_NUM instances.

## Test plan
- Reset, then write ch0 period=1000 high=300 en=1 -> TURBINE_OUT[0] rises 2 edges after the write; 300 cycles high, 700 low, rising edges 1000 cycles apart; other outputs stay 0.
- ch9 running period=100 high=50, write period=40 high=10 mid-period -> the current period completes at 50/100; the next period is exactly 10/40; no runt pulse.
- Edge values on ch3: period=2 high=1 -> alternating 1/0; high=0 -> constant 0 with wrap_o every 2 cycles; period=5 high=7 -> constant 1.
- Invalid and stop writes:
  - cfg_ch_i=12 with TURBINE_NUM=10 -> no channel changes.
  - period=1 en=1 on an idle channel -> it stays IDLE.
  - en=0 on a running channel -> the current period finishes, then IDLE and low.
- Write coinciding exactly with wrap_o on ch1 -> the new values apply starting from the immediately following period.
- Assert rst_n_i low during the high phase of all 10 channels -> all outputs 0 and busy_o=0 the next edge; after release, channels remain IDLE until rewritten.
